// File: rtl/slider_debounce_ctrl_if.sv
// Avalon-MM slave bus carrying register accesses to the slide-switch debounce controller.
interface slider_debounce_ctrl_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/slider_debounce_ctrl.sv
// Samples and debounces the slide switches on a prescaled tick, records changes in a
// W1C capture register and raises a maskable level interrupt.
module slider_debounce_ctrl #(
   parameter int WIDTH        = 10,
   parameter int DIV          = 50000,
   parameter int STABLE_TICKS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   slider_debounce_ctrl_if.slave bus,
   input  logic [WIDTH-1:0]     in_port,
   output logic                 irq
);
   localparam int             PW         = $clog2(DIV);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
   localparam logic [7:0]     RUN_LAST   = 8'(STABLE_TICKS - 1);

   typedef enum logic [1:0] {DISABLED, SETTLING, STABLE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sample;
   logic [WIDTH-1:0] candidate;
   logic [WIDTH-1:0] debounced;
   logic [WIDTH-1:0] capture;
   logic [WIDTH-1:0] mask;
   logic             ctrl_en;
   logic             ctrl_ie;
   logic [PW-1:0]    presc;
   logic [7:0]       run;
   logic             write_en;
   logic             tick;
   logic             commit;
   logic [WIDTH-1:0] cap_set;
   logic [WIDTH-1:0] cap_clr;
   logic [31:0]      read_mux;

   // run counts matching ticks including the one that loaded the candidate, so a
   // commit lands on the STABLE_TICKS-th tick; after a disable it restarts from zero.
   always_comb begin
      write_en = bus.chipselect && !bus.write_n;
      tick     = ctrl_en && (presc == PRESC_LAST);
      commit   = 1'b0;
      if (tick && state != DISABLED) begin
         if (sample != candidate)
            commit = (STABLE_TICKS == 1);
         else if (state == SETTLING)
            commit = (run == RUN_LAST);
      end
      cap_set = commit ? (sample ^ debounced) : '0;
      cap_clr = (write_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
      read_mux = '0;
      case (bus.address)
         2'd0:    read_mux[WIDTH-1:0] = debounced;
         2'd1:    read_mux[1:0]       = {ctrl_ie, ctrl_en};
         2'd2:    read_mux[WIDTH-1:0] = mask;
         default: read_mux[WIDTH-1:0] = capture;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= DISABLED;
         sync1       <= '0;
         sample      <= '0;
         candidate   <= '0;
         debounced   <= '0;
         capture     <= '0;
         mask        <= '0;
         ctrl_en     <= 1'b0;
         ctrl_ie     <= 1'b0;
         presc       <= '0;
         run         <= '0;
         bus.readdata <= '0;
         irq         <= 1'b0;
      end else begin
         sync1  <= in_port;
         sample <= sync1;
         presc  <= (!ctrl_en || tick) ? '0 : presc + 1'b1;

         if (write_en && bus.address == 2'd1)
            {ctrl_ie, ctrl_en} <= bus.writedata[1:0];
         if (write_en && bus.address == 2'd2)
            mask <= bus.writedata[WIDTH-1:0];

         // A commit setting a bit outranks a W1C clear of that bit in the same cycle.
         capture <= (capture & ~cap_clr) | cap_set;

         if (!ctrl_en) begin
            state <= DISABLED;
            run   <= '0;
         end else begin
            case (state)
               DISABLED: begin
                  state <= SETTLING;
                  run   <= '0;
               end
               default: begin
                  if (tick) begin
                     candidate <= sample;
                     if (commit) begin
                        debounced <= sample;
                        state     <= STABLE;
                        run       <= '0;
                     end else if (sample != candidate) begin
                        state <= SETTLING;
                        run   <= 8'd1;
                     end else if (state == SETTLING) begin
                        run <= run + 8'd1;
                     end
                  end
               end
            endcase
         end

         bus.readdata <= read_mux;
         irq          <= ctrl_ie && |(capture & mask);
      end
   end
endmodule

// File: tb/tb_slider_debounce_ctrl.sv
// Directed bench for slider_debounce_ctrl with a queue-based scoreboard on readdata and irq.
module tb_slider_debounce_ctrl;
   localparam int WIDTH = 10;
   localparam int DIV   = 4;
   localparam int ST    = 3;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] in_port;
   logic             irq;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   p0 = 0;
   logic rd_req = 1'b0;
   logic rd_pipe = 1'b0;
   exp_t rd_q[$];
   exp_t irq_q[$];
   exp_t mon_e;

   slider_debounce_ctrl_if bus();

   slider_debounce_ctrl #(.WIDTH(WIDTH), .DIV(DIV), .STABLE_TICKS(ST)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .in_port(in_port),
      .irq(irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rd_pipe <= rd_req;
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Read data appears the cycle after its address; irq expectations refer to the current cycle.
   always @(negedge clk) begin
      if (rd_pipe) begin
         if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: read returned with no expectation queued");
         end else begin
            mon_e = rd_q.pop_front();
            check_output(mon_e.name, bus.readdata, mon_e.exp);
         end
      end
      while (irq_q.size() > 0) begin
         mon_e = irq_q.pop_front();
         check_output(mon_e.name, {31'b0, irq}, mon_e.exp);
      end
   end

   function automatic int tk(input int k);
      return p0 + DIV * k;
   endfunction

   task automatic goto_cyc(input int n);
      if (cyc > n) begin
         errors++;
         $display("[TB] FAIL schedule: at cycle %0d, required <= %0d", cyc, n);
      end
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_stimulus(input logic [1:0] addr, input logic [31:0] data);
      bus.address    = addr;
      bus.writedata  = data;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(posedge clk);
      #1;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] addr, input logic [31:0] expected, input string name);
      exp_t e;
      e.name = name;
      e.exp  = expected;
      rd_q.push_back(e);
      bus.address = addr;
      rd_req      = 1'b1;
      @(posedge clk);
      #1;
      rd_req = 1'b0;
   endtask

   task automatic expect_irq(input logic value, input string name);
      exp_t e;
      e.name = name;
      e.exp  = {31'b0, value};
      irq_q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      reset          = 1'b1;
      in_port        = '0;
      bus.address    = '0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state of all registers
      expect_irq(1'b0, "t1 irq");
      bus_read(2'd0, 32'h0, "t1 state");
      bus_read(2'd1, 32'h0, "t1 ctrl");
      expect_irq(1'b0, "t1 irq late");
      bus_read(2'd2, 32'h0, "t1 mask");
      bus_read(2'd3, 32'h0, "t1 capture");

      // Basic debounce: load tick plus two more ticks commits
      in_port = 10'h3FF;
      apply_stimulus(2'd2, 32'h3FF);
      apply_stimulus(2'd1, 32'h3);
      p0 = cyc;
      bus_read(2'd1, 32'h3, "t2 ctrl");
      goto_cyc(tk(3) - 1);
      expect_irq(1'b0, "t2 irq before");
      bus_read(2'd0, 32'h0, "t2 state before");
      expect_irq(1'b0, "t2 irq commit cycle");
      bus_read(2'd0, 32'h3FF, "t2 state");
      expect_irq(1'b1, "t2 irq");
      bus_read(2'd3, 32'h3FF, "t2 capture");
      apply_stimulus(2'd3, 32'h3FF);
      expect_irq(1'b1, "t2 irq before clear");
      goto_cyc(tk(4));
      expect_irq(1'b0, "t2 irq cleared");

      // Bounce: bit0 differs from the candidate at every tick
      for (int i = 0; i < 11; i++) begin
         goto_cyc(tk(5 + i) - 3);
         in_port[0] = ~in_port[0];
         bus_read(2'd0, 32'h3FF, "t3 state bounce");
         bus_read(2'd3, 32'h0, "t3 capture bounce");
      end
      goto_cyc(tk(17) - 1);
      bus_read(2'd0, 32'h3FF, "t3 state before");
      bus_read(2'd0, 32'h3FE, "t3 state commit");
      bus_read(2'd3, 32'h001, "t3 capture");
      expect_irq(1'b1, "t3 irq");

      // W1C colliding with a commit on the same bit
      apply_stimulus(2'd3, 32'h001);
      goto_cyc(tk(19) - 3);
      in_port = 10'h3FF;
      bus_read(2'd3, 32'h0, "t4 capture cleared");
      goto_cyc(tk(21) - 1);
      apply_stimulus(2'd3, 32'h001);
      bus_read(2'd3, 32'h001, "t4 collision");
      bus_read(2'd0, 32'h3FF, "t4 state");
      expect_irq(1'b1, "t4 irq");
      apply_stimulus(2'd3, 32'h3FF);
      expect_irq(1'b1, "t4 irq before drop");
      goto_cyc(tk(21) + 4);
      expect_irq(1'b0, "t4 irq dropped");
      bus_read(2'd3, 32'h0, "t4 capture clr");

      // Mask only bit1, then change bit0 and bit1 in turn
      apply_stimulus(2'd2, 32'h002);
      goto_cyc(tk(24) - 3);
      in_port = 10'h3FE;
      goto_cyc(tk(26));
      bus_read(2'd3, 32'h001, "t5 capture bit0");
      expect_irq(1'b0, "t5 irq masked");
      bus_read(2'd0, 32'h3FE, "t5 state");
      expect_irq(1'b0, "t5 irq masked late");
      goto_cyc(tk(28) - 3);
      in_port = 10'h3FC;
      goto_cyc(tk(30));
      expect_irq(1'b0, "t5 irq before bit1");
      goto_cyc(tk(30) + 1);
      expect_irq(1'b1, "t5 irq bit1");
      bus_read(2'd3, 32'h003, "t5 capture bit1");
      apply_stimulus(2'd1, 32'h1);
      expect_irq(1'b1, "t5 irq before ie clear");
      goto_cyc(tk(30) + 4);
      expect_irq(1'b0, "t5 irq ie cleared");
      bus_read(2'd3, 32'h003, "t5 capture kept");

      // Disable after two ticks toward a new value; re-enable needs a full settle
      goto_cyc(tk(32) - 3);
      in_port = 10'h000;
      goto_cyc(tk(33) + 1);
      apply_stimulus(2'd1, 32'h0);
      bus_read(2'd1, 32'h0, "t6 ctrl");
      for (int i = 0; i < 10; i++) begin
         bus_read(2'd0, 32'h3FC, "t6 state disabled");
         @(posedge clk);
         #1;
      end
      apply_stimulus(2'd1, 32'h3);
      p0 = cyc;
      goto_cyc(tk(2));
      bus_read(2'd0, 32'h3FC, "t6 state two ticks");
      goto_cyc(tk(3) - 1);
      bus_read(2'd0, 32'h3FC, "t6 state before");
      bus_read(2'd0, 32'h000, "t6 state commit");
      bus_read(2'd3, 32'h3FF, "t6 capture");
      expect_irq(1'b1, "t6 irq");

      // Reset mid-operation
      in_port = 10'h155;
      reset   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      expect_irq(1'b0, "t7 irq");
      bus_read(2'd0, 32'h0, "t7 state");
      bus_read(2'd1, 32'h0, "t7 ctrl");
      bus_read(2'd2, 32'h0, "t7 mask");
      bus_read(2'd3, 32'h0, "t7 capture");
      expect_irq(1'b0, "t7 irq late");

      repeat (3) @(posedge clk);
      #1;
      if (rd_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d reads outstanding, expected 0", rd_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
